ahb_arbiter: RTL and testbench

- AHB-2 bus arbiter and master-select generator. It shares one AHB segment between up to 4 bus masters, for example the DMA master port (M_HBUSREQ/M_HGRANT) plus CPU or test masters.
- It drives the HGRANT vector, the address-phase owner index and the data-phase owner index. These indices steer the external address/control and write-data muxes.
- It tracks fixed-length bursts and locked transfers, so ownership changes only at legal AHB handover points.

---
 rtl/ahb_defs.sv | 44 ++++
 rtl/ahb_arb_rr.sv | 28 ++
 rtl/ahb_arbiter.sv | 100 ++++++++++
 tb/tb_ahb_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_defs.sv
// Shared AHB-2 encodings and burst helpers used by the arbiter slice.
package ahb_defs;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    HR_OKAY  = 2'd0,
    HR_ERROR = 2'd1,
    HR_RETRY = 2'd2,
    HR_SPLIT = 2'd3
  } hresp_e;

  // Fixed-length bursts are the only ones that must not be broken.
  function automatic logic is_fixed(input logic [2:0] burst);
    return burst >= 3'(HB_WRAP4);
  endfunction

  // Remaining beats after the NONSEQ beat of a burst.
  function automatic logic [3:0] beats_left(input logic [2:0] burst);
    case (burst)
      HB_WRAP4,  HB_INCR4:  return 4'd3;
      HB_WRAP8,  HB_INCR8:  return 4'd7;
      HB_WRAP16, HB_INCR16: return 4'd15;
      default:              return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb_rr.sv
// Combinational round-robin picker: searches (rr+1) mod NUM_M through rr.
module ahb_arb_rr #(
  parameter int NUM_M = 4
) (
  input  logic [NUM_M-1:0] req,
  input  logic [1:0]       rr,
  output logic [NUM_M-1:0] win,
  output logic             valid
);

  logic [1:0] idx;

  // First requester after the pointer wins; the pointer holder is checked last.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_M; i++) begin
      idx = 2'((int'(rr) + i) % NUM_M);
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB-2 arbiter: round-robin grant, burst/lock aware handover, owner pipeline.
module ahb_arbiter
  import ahb_defs::*;
#(
  parameter int NUM_M = 4,
  parameter int DEF_M = 0
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [NUM_M-1:0] HBUSREQ,
  input  logic [NUM_M-1:0] HLOCK,
  input  logic [1:0]       HTRANS,
  input  logic [2:0]       HBURST,
  input  logic [1:0]       HRESP,
  input  logic             HREADY,
  output logic [NUM_M-1:0] HGRANT,
  output logic [1:0]       HMASTER,
  output logic [1:0]       HMASTER_D,
  output logic             HMASTLOCK
);

  localparam logic [NUM_M-1:0] DEF_GRANT = NUM_M'(1) << DEF_M;

  logic [3:0]       bcnt;
  logic [1:0]       rr;
  logic [1:0]       gidx;
  logic [NUM_M-1:0] win;
  logic             win_valid;
  logic             hop;
  logic             lk;
  htrans_e          trans;

  assign trans = htrans_e'(HTRANS);

  // Index of the currently granted master (HGRANT is always one-hot).
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (HGRANT[i]) gidx = 2'(i);
    end
  end

  // Legal handover: no fixed burst in flight, last beat issuing, or idle bus.
  assign hop = ((bcnt == 4'd0) && !((trans == HT_NONSEQ) && is_fixed(HBURST)))
            || ((bcnt == 4'd1) && (trans == HT_SEQ))
            || (trans == HT_IDLE);

  // Locked master keeps the bus as long as it keeps requesting.
  assign lk = HLOCK[gidx] && HBUSREQ[gidx];

  ahb_arb_rr #(.NUM_M(NUM_M)) u_rr (
    .req   (HBUSREQ),
    .rr    (rr),
    .win   (win),
    .valid (win_valid)
  );

  // Burst beat counter; an ERROR wait state terminates the burst.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      bcnt <= '0;
    end else if (!HREADY) begin
      if (hresp_e'(HRESP) == HR_ERROR) bcnt <= '0;
    end else begin
      case (trans)
        HT_NONSEQ: bcnt <= beats_left(HBURST);
        HT_SEQ:    if (bcnt != 4'd0) bcnt <= bcnt - 4'd1;
        HT_IDLE:   bcnt <= '0;
        default:   bcnt <= bcnt;
      endcase
    end
  end

  // Grant, round-robin pointer and address/data owner pipeline.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HGRANT    <= DEF_GRANT;
      rr        <= 2'(DEF_M);
      HMASTER   <= 2'(DEF_M);
      HMASTER_D <= 2'(DEF_M);
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      if (hop && !lk) begin
        if (win_valid) begin
          HGRANT <= win;
          for (int i = 0; i < NUM_M; i++) begin
            if (win[i]) rr <= 2'(i);
          end
        end else begin
          HGRANT <= DEF_GRANT;
        end
      end
      HMASTER   <= gidx;
      HMASTLOCK <= HLOCK[gidx];
      HMASTER_D <= HMASTER;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: vector table plus hand-written corner sequences.
module tb_ahb_arbiter;
  import ahb_defs::*;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] HBUSREQ, HLOCK;
  logic [1:0] HTRANS, HRESP;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER, HMASTER_D;
  logic       HMASTLOCK;

  int total = 0;
  int bad   = 0;

  ahb_arbiter #(.NUM_M(4), .DEF_M(0)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HRESP     (HRESP),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTER_D (HMASTER_D),
    .HMASTLOCK (HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic [1:0] resp;
    logic       ready;
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] md;
    logic       ml;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] md;
    logic       ml;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic void add(string name, logic rst, logic [3:0] req, logic [3:0] lock,
                              logic [1:0] trans, logic [2:0] burst, logic [1:0] resp,
                              logic ready, logic [3:0] g, logic [1:0] m, logic [1:0] md,
                              logic ml);
    vec_t v;
    v.name = name; v.rst = rst; v.req = req; v.lock = lock; v.trans = trans;
    v.burst = burst; v.resp = resp; v.ready = ready;
    v.g = g; v.m = m; v.md = md; v.ml = ml;
    tbl.push_back(v);
  endfunction

  task automatic check(input exp_t e);
    total++;
    if (HGRANT !== e.g || HMASTER !== e.m || HMASTER_D !== e.md || HMASTLOCK !== e.ml) begin
      bad++;
      $display("FAIL %s: got grant=%b master=%0d master_d=%0d mlock=%b, want grant=%b master=%0d master_d=%0d mlock=%b",
               e.name, HGRANT, HMASTER, HMASTER_D, HMASTLOCK, e.g, e.m, e.md, e.ml);
    end
  endtask

  // Drive one cycle at the falling edge, queue its expectation, compare after the rising edge.
  task automatic step(input string name, input logic rst, input logic [3:0] req,
                      input logic [3:0] lock, input logic [1:0] trans, input logic [2:0] burst,
                      input logic [1:0] resp, input logic ready, input logic [3:0] g,
                      input logic [1:0] m, input logic [1:0] md, input logic ml);
    exp_t e;
    @(negedge HCLK);
    HRESET = rst; HBUSREQ = req; HLOCK = lock; HTRANS = trans;
    HBURST = burst; HRESP = resp; HREADY = ready;
    e.name = name; e.g = g; e.m = m; e.md = md; e.ml = ml;
    sb.push_back(e);
    @(posedge HCLK);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check(sb.pop_front());
    end
  endtask

  // Reset, grant master 2, start an INCR16 with master 1 competing; three beats issued.
  task automatic m2_incr16_start(input string tag);
    step({tag, "_rst"},  1'b1, 4'b0000, 4'b0, HT_IDLE,   HB_SINGLE, HR_OKAY, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);
    step({tag, "_req"},  1'b0, 4'b0100, 4'b0, HT_IDLE,   HB_SINGLE, HR_OKAY, 1'b1, 4'b0100, 2'd0, 2'd0, 1'b0);
    step({tag, "_own"},  1'b0, 4'b0100, 4'b0, HT_IDLE,   HB_SINGLE, HR_OKAY, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b0);
    step({tag, "_b1"},   1'b0, 4'b0110, 4'b0, HT_NONSEQ, HB_INCR16, HR_OKAY, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
    step({tag, "_b2"},   1'b0, 4'b0110, 4'b0, HT_SEQ,    HB_INCR16, HR_OKAY, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
    step({tag, "_b3"},   1'b0, 4'b0110, 4'b0, HT_SEQ,    HB_INCR16, HR_OKAY, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
  endtask

  initial begin
    HRESET = 1'b1; HBUSREQ = '0; HLOCK = '0; HTRANS = HT_IDLE;
    HBURST = HB_SINGLE; HRESP = HR_OKAY; HREADY = 1'b1;

    // Reset state held for 10 idle cycles.
    add("rst", 1'b1, 4'b0000, 4'b0, HT_IDLE, HB_SINGLE, HR_OKAY, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++)
      add("idle_hold", 1'b0, 4'b0000, 4'b0, HT_IDLE, HB_SINGLE, HR_OKAY, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);

    // Two simultaneous requesters alternate 1,2,1,2.
    add("rr_a", 1'b0, 4'b0110, 4'b0, HT_IDLE, HB_SINGLE, HR_OKAY, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
    add("rr_b", 1'b0, 4'b0110, 4'b0, HT_IDLE, HB_SINGLE, HR_OKAY, 1'b1, 4'b0100, 2'd1, 2'd0, 1'b0);
    add("rr_c", 1'b0, 4'b0110, 4'b0, HT_IDLE, HB_SINGLE, HR_OKAY, 1'b1, 4'b0010, 2'd2, 2'd1, 1'b0);
    add("rr_d", 1'b0, 4'b0110, 4'b0, HT_IDLE, HB_SINGLE, HR_OKAY, 1'b1, 4'b0100, 2'd1, 2'd2, 1'b0);

    // INCR8 from master 1; master 3 waits for the 8th beat.
    add("i8_rst", 1'b1, 4'b0000, 4'b0, HT_IDLE, HB_SINGLE, HR_OKAY, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);
    add("i8_req", 1'b0, 4'b0010, 4'b0, HT_IDLE, HB_SINGLE, HR_OKAY, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
    add("i8_own", 1'b0, 4'b0010, 4'b0, HT_IDLE, HB_SINGLE, HR_OKAY, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0);
    add("i8_b1",  1'b0, 4'b0010, 4'b0, HT_NONSEQ, HB_INCR8, HR_OKAY, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    for (int i = 2; i <= 7; i++)
      add("i8_mid", 1'b0, 4'b1010, 4'b0, HT_SEQ, HB_INCR8, HR_OKAY, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    add("i8_b8",  1'b0, 4'b1010, 4'b0, HT_SEQ,  HB_INCR8, HR_OKAY, 1'b1, 4'b1000, 2'd1, 2'd1, 1'b0);
    add("i8_hm3", 1'b0, 4'b1000, 4'b0, HT_IDLE, HB_SINGLE, HR_OKAY, 1'b1, 4'b1000, 2'd3, 2'd1, 1'b0);

    foreach (tbl[k])
      step(tbl[k].name, tbl[k].rst, tbl[k].req, tbl[k].lock, tbl[k].trans, tbl[k].burst,
           tbl[k].resp, tbl[k].ready, tbl[k].g, tbl[k].m, tbl[k].md, tbl[k].ml);

    // INCR4 with three wait states on beat 2: everything frozen, handover after beat 4.
    step("i4_rst",  1'b1, 4'b0000, 4'b0, HT_IDLE,   HB_SINGLE, HR_OKAY, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);
    step("i4_req",  1'b0, 4'b0010, 4'b0, HT_IDLE,   HB_SINGLE, HR_OKAY, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
    step("i4_own",  1'b0, 4'b0010, 4'b0, HT_IDLE,   HB_SINGLE, HR_OKAY, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0);
    step("i4_b1",   1'b0, 4'b1010, 4'b0, HT_NONSEQ, HB_INCR4,  HR_OKAY, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++)
      step("i4_wait", 1'b0, 4'b1010, 4'b0, HT_SEQ,  HB_INCR4,  HR_OKAY, 1'b0, 4'b0010, 2'd1, 2'd1, 1'b0);
    step("i4_b2",   1'b0, 4'b1010, 4'b0, HT_SEQ,    HB_INCR4,  HR_OKAY, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    step("i4_b3",   1'b0, 4'b1010, 4'b0, HT_SEQ,    HB_INCR4,  HR_OKAY, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    step("i4_b4",   1'b0, 4'b1010, 4'b0, HT_SEQ,    HB_INCR4,  HR_OKAY, 1'b1, 4'b1000, 2'd1, 2'd1, 1'b0);
    step("i4_hm3",  1'b0, 4'b1000, 4'b0, HT_IDLE,   HB_SINGLE, HR_OKAY, 1'b1, 4'b1000, 2'd3, 2'd1, 1'b0);

    // Locked master 2 holds the bus against master 0 until HLOCK falls.
    step("lk_rst",  1'b1, 4'b0000, 4'b0000, HT_IDLE,   HB_SINGLE, HR_OKAY, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);
    step("lk_req",  1'b0, 4'b0100, 4'b0100, HT_IDLE,   HB_SINGLE, HR_OKAY, 1'b1, 4'b0100, 2'd0, 2'd0, 1'b0);
    step("lk_own",  1'b0, 4'b0100, 4'b0100, HT_IDLE,   HB_SINGLE, HR_OKAY, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b1);
    step("lk_s1",   1'b0, 4'b0101, 4'b0100, HT_NONSEQ, HB_SINGLE, HR_OKAY, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b1);
    step("lk_s2",   1'b0, 4'b0101, 4'b0100, HT_NONSEQ, HB_SINGLE, HR_OKAY, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b1);
    step("lk_drop", 1'b0, 4'b0101, 4'b0000, HT_NONSEQ, HB_SINGLE, HR_OKAY, 1'b1, 4'b0001, 2'd2, 2'd2, 1'b0);
    step("lk_hm0",  1'b0, 4'b0001, 4'b0000, HT_IDLE,   HB_SINGLE, HR_OKAY, 1'b1, 4'b0001, 2'd0, 2'd2, 1'b0);

    // ERROR on beat 3 of INCR16: wait state frozen, handover on the following IDLE.
    m2_incr16_start("er");
    step("er_wait", 1'b0, 4'b0110, 4'b0, HT_SEQ,  HB_INCR16, HR_ERROR, 1'b0, 4'b0100, 2'd2, 2'd2, 1'b0);
    step("er_idle", 1'b0, 4'b0110, 4'b0, HT_IDLE, HB_INCR16, HR_ERROR, 1'b1, 4'b0010, 2'd2, 2'd2, 1'b0);

    // Same, but the ERROR completion cycle is BUSY: only a cleared counter allows handover.
    m2_incr16_start("eb");
    step("eb_wait", 1'b0, 4'b0110, 4'b0, HT_SEQ,  HB_INCR16, HR_ERROR, 1'b0, 4'b0100, 2'd2, 2'd2, 1'b0);
    step("eb_busy", 1'b0, 4'b0110, 4'b0, HT_BUSY, HB_INCR16, HR_ERROR, 1'b1, 4'b0010, 2'd2, 2'd2, 1'b0);

    // Reset on beat 5 of INCR16 discards the burst.
    m2_incr16_start("rb");
    step("rb_b4",   1'b0, 4'b0110, 4'b0, HT_SEQ, HB_INCR16, HR_OKAY, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
    step("rb_rst",  1'b1, 4'b0110, 4'b0, HT_SEQ, HB_INCR16, HR_OKAY, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);
    step("rb_seq",  1'b0, 4'b0010, 4'b0, HT_SEQ, HB_INCR16, HR_OKAY, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
